// File: rtl/iot_pkg.sv
// Shared definitions for the IOT multiplexer: CPU major-state codes, field widths and FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package iot_pkg;

  localparam int WORD_W = 12;
  localparam int DEV_W  = 6;

  localparam logic [2:0] IOT_OP = 3'o6;

  // CPU major-state codes, shared with the CPU sequencer
  localparam logic [4:0] F1 = 5'b00001;
  localparam logic [4:0] F2 = 5'b00010;
  localparam logic [4:0] F3 = 5'b00100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } iot_fsm_t;

  // Width of a channel index; a single channel still needs one bit
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iot_dev_decode.sv
// Priority matcher from the opcode/device field of an instruction to a channel index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever the instruction is.
module iot_dev_decode
  import iot_pkg::*;
#(
  parameter int                     NDEV      = 4,
  parameter logic [NDEV*DEV_W-1:0]  DEV_CODES = '0,
  parameter int                     SEL_W     = 2
) (
  input  logic [0:8]       op_dev,
  output logic             iot,
  output logic             hit,
  output logic [SEL_W-1:0] sel
);

  logic [DEV_W-1:0] dev;
  logic             match;

  assign iot = (op_dev[0:2] == IOT_OP);
  assign dev = op_dev[3:8];
  assign hit = iot & match;

  // Scan from the top channel down so the lowest matching index is the last one written
  always_comb begin
    match = 1'b0;
    sel   = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (DEV_CODES[i*DEV_W +: DEV_W] == dev) begin
        match = 1'b1;
        sel   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/iot_mux_n.sv
// IOT multiplexer: routes CPU IOT instructions to one of NDEV device channels and returns data/skip.
// Latency: strobe one cycle after F2 is seen; capture one cycle after the device reports ready.
// Backpressure: stall holds the CPU in F2 until ready or until TIMEOUT wait cycles have elapsed.
module iot_mux_n
  import iot_pkg::*;
#(
  parameter int                     NDEV      = 4,
  parameter logic [NDEV*DEV_W-1:0]  DEV_CODES = {6'o74, 6'o21, 6'o04, 6'o03},
  parameter int                     TIMEOUT   = 15,
  parameter int                     CNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               state,
  input  logic [0:WORD_W-1]        instruction,
  input  logic [WORD_W-1:0]        ac,
  input  logic [NDEV*WORD_W-1:0]   dev_data,
  input  logic [NDEV-1:0]          dev_skip,
  input  logic [NDEV-1:0]          dev_ready,
  input  logic                     timeout_clr,
  output logic [NDEV-1:0]          iot_strobe,
  output logic                     stall,
  output logic [WORD_W-1:0]        in_bus,
  output logic                     skip,
  output logic [WORD_W-1:0]        bus_display,
  output logic                     iot_timeout
);

  localparam int SEL_W = sel_width(NDEV);

  iot_fsm_t           fsm;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   sel_q;
  logic [WORD_W-1:0]  lac;
  logic [CNT_W-1:0]   cnt;
  logic               iot;
  logic               hit;
  logic               is_f2;
  logic [NDEV-1:0]    strobe_onehot;
  logic [WORD_W-1:0]  sel_data;
  logic               sel_ready;
  logic               sel_skip;
  logic               read_pulse;
  logic               unused_instr_bits;

  iot_dev_decode #(
    .NDEV      (NDEV),
    .DEV_CODES (DEV_CODES),
    .SEL_W     (SEL_W)
  ) u_decode (
    .op_dev (instruction[0:8]),
    .iot    (iot),
    .hit    (hit),
    .sel    (sel)
  );

  assign is_f2      = (state == F2);
  assign read_pulse = instruction[10];
  // Bits 9 and 11 are device-private micro-op bits; only the read pulse matters here
  assign unused_instr_bits = instruction[9] ^ instruction[11];

  assign sel_data  = dev_data[sel_q*WORD_W +: WORD_W];
  assign sel_ready = dev_ready[sel_q];
  assign sel_skip  = dev_skip[sel_q];

  // Stall is raised in the very F2 cycle that decodes a hit, and is forced low while in reset
  assign stall = !reset && (((fsm == IDLE) && is_f2 && hit) || (fsm == WAIT));

  // One-hot strobe pattern for the channel being decoded this cycle
  always_comb begin
    strobe_onehot      = '0;
    strobe_onehot[sel] = 1'b1;
  end

  // Transaction FSM together with the wait counter and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm         <= IDLE;
      sel_q       <= '0;
      lac         <= '0;
      cnt         <= '0;
      in_bus      <= '0;
      skip        <= 1'b0;
      bus_display <= '0;
      iot_strobe  <= '0;
      iot_timeout <= 1'b0;
    end else begin
      iot_strobe <= '0;
      // A timeout set later in this block overrides a simultaneous clear
      if (timeout_clr) iot_timeout <= 1'b0;

      case (fsm)
        IDLE: begin
          if (is_f2 && hit) begin
            sel_q      <= sel;
            lac        <= ac;
            iot_strobe <= strobe_onehot;
            cnt        <= '0;
            fsm        <= WAIT;
          end else if (is_f2 && iot) begin
            in_bus <= '0;
            skip   <= 1'b0;
            fsm    <= DONE;
          end
        end
        WAIT: begin
          if (sel_ready) begin
            in_bus      <= sel_data;
            skip        <= sel_skip;
            bus_display <= read_pulse ? sel_data : lac;
            fsm         <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            in_bus      <= '0;
            skip        <= 1'b0;
            iot_timeout <= 1'b1;
            fsm         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Wait for the CPU to leave F2 so the same instruction cannot fire twice
          if (!is_f2) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase

      // The returned word is only meaningful until the next fetch
      if (state == F1) begin
        in_bus <= '0;
        skip   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iot_mux_n.sv
// Bench for iot_mux_n: table of IOT transactions checked through a scoreboard queue,
// plus hand sequences for reset during WAIT and duplicate device codes.
// All stimulus is driven 1 time unit after the rising edge and sampled 1 unit later.
module tb_iot_mux_n;
  import iot_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [4:0]        state;
  logic [0:11]       instruction;
  logic [11:0]       ac;
  logic [47:0]       dev_data;
  logic [3:0]        dev_skip;
  logic [3:0]        dev_ready;
  logic              timeout_clr;

  logic [3:0]        iot_strobe, d2_iot_strobe;
  logic              stall, d2_stall;
  logic [11:0]       in_bus, d2_in_bus;
  logic              skip, d2_skip;
  logic [11:0]       bus_display, d2_bus_display;
  logic              iot_timeout, d2_iot_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iot_mux_n #(
    .NDEV(4), .DEV_CODES({6'o74, 6'o21, 6'o04, 6'o03}), .TIMEOUT(15), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .state(state), .instruction(instruction), .ac(ac),
    .dev_data(dev_data), .dev_skip(dev_skip), .dev_ready(dev_ready), .timeout_clr(timeout_clr),
    .iot_strobe(iot_strobe), .stall(stall), .in_bus(in_bus), .skip(skip),
    .bus_display(bus_display), .iot_timeout(iot_timeout)
  );

  // Channels 0 and 2 share code 74
  iot_mux_n #(
    .NDEV(4), .DEV_CODES({6'o21, 6'o74, 6'o04, 6'o74}), .TIMEOUT(15), .CNT_W(4)
  ) dut2 (
    .clk(clk), .reset(reset), .state(state), .instruction(instruction), .ac(ac),
    .dev_data(dev_data), .dev_skip(dev_skip), .dev_ready(dev_ready), .timeout_clr(timeout_clr),
    .iot_strobe(d2_iot_strobe), .stall(d2_stall), .in_bus(d2_in_bus), .skip(d2_skip),
    .bus_display(d2_bus_display), .iot_timeout(d2_iot_timeout)
  );

  typedef struct {
    logic [11:0] instr;
    logic [11:0] acv;
    int          ch;
    int          rdy;       // cycle index at which ready is driven, -1 for never
    logic [11:0] data;
    logic        skp;
    logic        tclr;      // timeout_clr held for the whole transaction
    logic [3:0]  e_strobe;
    int          e_stall;
    logic [11:0] e_bus;
    logic        e_skip;
    logic [11:0] e_disp;
    logic        e_to_done;
    logic        e_to_end;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];
  vec_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o, expected %0o", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int          cyc;
    int          stall_cnt;
    int          strb_cnt;
    logic [3:0]  strb_or;
    logic        seen_low;
    logic        to_done;
    logic        to_end;
    logic [11:0] bus_q;
    logic        skip_q;
    logic [11:0] disp_q;
    vec_t        e;

    tick();
    state       = F2;
    instruction = v.instr;
    ac          = v.acv;
    timeout_clr = v.tclr;
    dev_data    = {4{12'o0707}};
    dev_data[v.ch*12 +: 12] = v.data;
    dev_skip    = v.skp ? (4'b0001 << v.ch) : 4'b0000;
    sb.push_back(v);

    cyc = 0; stall_cnt = 0; strb_cnt = 0; strb_or = '0; seen_low = 1'b0;
    while (!seen_low && cyc < 40) begin
      dev_ready = (cyc == v.rdy) ? (4'b0001 << v.ch) : 4'b0000;
      #1;
      if (iot_strobe != 4'b0000) begin
        strb_cnt++;
        strb_or |= iot_strobe;
      end
      if (!stall) seen_low = 1'b1;
      else begin
        stall_cnt++;
        cyc++;
        tick();
      end
    end
    chk($sformatf("r%0d_stall_released", idx), seen_low, 1'b1);
    to_done = iot_timeout;

    // One more F2 cycle in DONE: results settled, nothing retriggers
    tick();
    dev_ready = 4'b0000;
    #1;
    if (iot_strobe != 4'b0000) begin
      strb_cnt++;
      strb_or |= iot_strobe;
    end
    chk($sformatf("r%0d_no_retrigger_stall", idx), stall, 1'b0);
    bus_q  = in_bus;
    skip_q = skip;
    disp_q = bus_display;
    to_end = iot_timeout;

    e = sb.pop_front();
    chk($sformatf("r%0d_strobe", idx), strb_or, e.e_strobe);
    chk($sformatf("r%0d_strobe_cycles", idx), strb_cnt, (e.e_strobe != 4'b0000) ? 1 : 0);
    chk($sformatf("r%0d_stall_cycles", idx), stall_cnt, e.e_stall);
    chk($sformatf("r%0d_in_bus", idx), bus_q, e.e_bus);
    chk($sformatf("r%0d_skip", idx), skip_q, e.e_skip);
    chk($sformatf("r%0d_bus_display", idx), disp_q, e.e_disp);
    chk($sformatf("r%0d_timeout_at_done", idx), to_done, e.e_to_done);
    chk($sformatf("r%0d_timeout_after", idx), to_end, e.e_to_end);

    // Leave F2, then pass through F1 which must clear the returned word
    tick();
    state       = F3;
    timeout_clr = 1'b0;
    tick();
    state = F1;
    tick();
    state = F3;
    #1;
    chk($sformatf("r%0d_f1_clear_in_bus", idx), in_bus, 12'o0000);
    chk($sformatf("r%0d_f1_clear_skip", idx), skip, 1'b0);
  endtask

  initial begin
    //            instr     ac        ch rdy data      skp tclr strobe  stall bus       skip disp      to_d to_e
    vecs[0] = '{12'o6046, 12'o5555, 1,  1, 12'o1234, 1'b1, 1'b0, 4'b0010,  2, 12'o1234, 1'b1, 12'o1234, 1'b0, 1'b0};
    vecs[1] = '{12'o6031, 12'o7070, 0,  5, 12'o4321, 1'b1, 1'b0, 4'b0001,  6, 12'o4321, 1'b1, 12'o7070, 1'b0, 1'b0};
    vecs[2] = '{12'o6214, 12'o1111, 2, -1, 12'o2222, 1'b1, 1'b0, 4'b0100, 16, 12'o0000, 1'b0, 12'o7070, 1'b1, 1'b1};
    vecs[3] = '{12'o6551, 12'o6666, 0, -1, 12'o3333, 1'b1, 1'b1, 4'b0000,  0, 12'o0000, 1'b0, 12'o7070, 1'b1, 1'b0};
    vecs[4] = '{12'o6746, 12'o0707, 3,  3, 12'o7654, 1'b0, 1'b0, 4'b1000,  4, 12'o7654, 1'b0, 12'o7654, 1'b0, 1'b0};
    vecs[5] = '{12'o6044, 12'o1212, 1, -1, 12'o4444, 1'b1, 1'b1, 4'b0010, 16, 12'o0000, 1'b0, 12'o7654, 1'b1, 1'b0};
    vecs[6] = '{12'o6211, 12'o3456, 2, 15, 12'o1357, 1'b1, 1'b0, 4'b0100, 16, 12'o1357, 1'b1, 12'o3456, 1'b0, 1'b0};

    reset       = 1'b1;
    state       = F3;
    instruction = 12'o0000;
    ac          = 12'o0000;
    dev_data    = '0;
    dev_skip    = '0;
    dev_ready   = '0;
    timeout_clr = 1'b0;

    tick();
    tick();
    #1;
    chk("reset_stall", stall, 1'b0);
    chk("reset_strobe", iot_strobe, 4'b0000);
    chk("reset_in_bus", in_bus, 12'o0000);
    chk("reset_skip", skip, 1'b0);
    chk("reset_bus_display", bus_display, 12'o0000);
    chk("reset_timeout", iot_timeout, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) run_txn(i, vecs[i]);
    chk("scoreboard_drained", sb.size(), 0);

    // Reset in the middle of WAIT, then a fresh IOT while the CPU stays in F2
    tick();
    state       = F2;
    instruction = 12'o6046;
    ac          = 12'o0123;
    dev_data    = {4{12'o0707}};
    dev_data[12 +: 12] = 12'o1234;
    dev_skip    = 4'b0010;
    dev_ready   = 4'b0000;
    #1;
    chk("rst_seq_stall_c0", stall, 1'b1);
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_seq_stall_in_reset", stall, 1'b0);
    tick();
    #1;
    chk("rst_seq_stall_after", stall, 1'b0);
    chk("rst_seq_strobe", iot_strobe, 4'b0000);
    chk("rst_seq_in_bus", in_bus, 12'o0000);
    chk("rst_seq_skip", skip, 1'b0);
    chk("rst_seq_bus_display", bus_display, 12'o0000);
    chk("rst_seq_timeout", iot_timeout, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_seq_restall", stall, 1'b1);
    tick();
    #1;
    chk("rst_seq_new_strobe", iot_strobe, 4'b0010);
    dev_ready = 4'b0010;
    tick();
    dev_ready = 4'b0000;
    #1;
    chk("rst_seq_done_stall", stall, 1'b0);
    chk("rst_seq_in_bus_cap", in_bus, 12'o1234);
    chk("rst_seq_disp_cap", bus_display, 12'o1234);
    tick();
    state = F3;
    tick();

    // Duplicate code 74 on channels 0 and 2 of dut2: channel 0 must win
    tick();
    state       = F2;
    instruction = 12'o6745;
    ac          = 12'o0246;
    dev_data    = {12'o3333, 12'o2222, 12'o5555, 12'o1111};
    dev_skip    = 4'b0001;
    dev_ready   = 4'b0000;
    #1;
    chk("dup_stall_c0", d2_stall, 1'b1);
    tick();
    dev_ready = 4'b1101;
    #1;
    chk("dup_strobe", d2_iot_strobe, 4'b0001);
    chk("dup_dut1_strobe", iot_strobe, 4'b1000);
    tick();
    dev_ready = 4'b0000;
    #1;
    chk("dup_stall_done", d2_stall, 1'b0);
    chk("dup_in_bus", d2_in_bus, 12'o1111);
    chk("dup_skip", d2_skip, 1'b1);
    chk("dup_bus_display", d2_bus_display, 12'o0246);
    chk("dup_dut1_in_bus", in_bus, 12'o3333);
    tick();
    state = F3;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
